// File: rtl/uart_calc_pkg.sv
// Shared constants, FSM state encoding and nibble-to-ASCII helper for the UART calculator response path.
// UART_RESP_CRLF_EN adds the TERM_CR state (CR LF terminator instead of LF only).
package uart_calc_pkg;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

`ifdef UART_RESP_CRLF_EN
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DIGIT   = 2'd1,
        ST_TERM_CR = 2'd2,
        ST_TERM_LF = 2'd3
    } fmt_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DIGIT   = 2'd1,
        ST_TERM_LF = 2'd3
    } fmt_state_e;
`endif

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n < 4'd10) begin
            return ASCII_0 + {4'h0, n};
        end
        return ASCII_A + {4'h0, n} - 8'd10;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Show-ahead byte FIFO; a write and a pop in the same cycle leave the count unchanged, even when full.
module byte_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   cnt
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_wr, do_rd;

    assign do_rd = rd_en && (cnt_q != '0);
    assign do_wr = wr_en && ((cnt_q != (AW+1)'(DEPTH)) || do_rd);

    always_comb begin
        cnt_d = cnt_q;
        if (do_wr && !do_rd) begin
            cnt_d = cnt_q + (AW+1)'(1);
        end else if (!do_wr && do_rd) begin
            cnt_d = cnt_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q <= cnt_d;
        end
    end

    // Storage is not reset; the empty gate below keeps stale contents off rd_data.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = (cnt_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign cnt     = cnt_q;

endmodule

// File: rtl/uart_resp_fmt.sv
// Merges the RX echo stream and ALU results (as uppercase hex plus terminator) into one TX byte FIFO.
// UART_RESP_CRLF_EN selects a CR LF terminator; otherwise LF only.
module uart_resp_fmt
    import uart_calc_pkg::*;
#(
    parameter int RES_W       = 32,
    parameter int DEPTH       = 16,
    parameter int SUPPRESS_LZ = 1
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic [7:0]             echo_data,
    input  logic                   echo_valid,
    input  logic [RES_W-1:0]       res_data,
    input  logic                   res_valid,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic [$clog2(DEPTH):0] fifo_cnt,
    output logic                   busy,
    output logic                   echo_drop,
    output logic                   res_drop
);
    localparam int NDIG  = RES_W / 4;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    fmt_state_e       state_q, state_d;
    logic [RES_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             lz_q, lz_d;
    logic             echo_drop_q, res_drop_q;

    logic       pop, slot_ok, grant_ok, echo_wr, fmt_req, fmt_wr, wr_en;
    logic [7:0] fmt_byte, wr_data;
    logic [3:0] nib;

    assign pop      = tx_valid && tx_ready;
    assign slot_ok  = (fifo_cnt != CNT_W'(DEPTH)) || pop;
    assign grant_ok = slot_ok && !echo_valid;
    assign echo_wr  = echo_valid && slot_ok;
    assign fmt_wr   = fmt_req && grant_ok;
    assign wr_en    = echo_wr || fmt_wr;
    assign wr_data  = echo_valid ? echo_data : fmt_byte;
    assign nib      = shift_q[RES_W-1 -: 4];

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        lz_d     = lz_q;
        fmt_req  = 1'b0;
        fmt_byte = 8'h00;
        case (state_q)
            ST_IDLE: begin
                if (res_valid) begin
                    shift_d = res_data;
                    idx_d   = IDX_W'(NDIG - 1);
                    lz_d    = (SUPPRESS_LZ != 0);
                    state_d = ST_DIGIT;
                end
            end
            ST_DIGIT: begin
                // The last digit is never skipped so an all-zero result still prints "0".
                if (lz_q && (nib == 4'h0) && (idx_q != '0)) begin
                    shift_d = shift_q << 4;
                    idx_d   = idx_q - IDX_W'(1);
                end else begin
                    fmt_req  = 1'b1;
                    fmt_byte = hex_ascii(nib);
                    if (grant_ok) begin
                        lz_d    = 1'b0;
                        shift_d = shift_q << 4;
                        if (idx_q == '0) begin
`ifdef UART_RESP_CRLF_EN
                            state_d = ST_TERM_CR;
`else
                            state_d = ST_TERM_LF;
`endif
                        end else begin
                            idx_d = idx_q - IDX_W'(1);
                        end
                    end
                end
            end
`ifdef UART_RESP_CRLF_EN
            ST_TERM_CR: begin
                fmt_req  = 1'b1;
                fmt_byte = ASCII_CR;
                if (grant_ok) state_d = ST_TERM_LF;
            end
`endif
            ST_TERM_LF: begin
                fmt_req  = 1'b1;
                fmt_byte = ASCII_LF;
                if (grant_ok) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            idx_q       <= '0;
            lz_q        <= 1'b0;
            echo_drop_q <= 1'b0;
            res_drop_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            idx_q       <= idx_d;
            lz_q        <= lz_d;
            echo_drop_q <= echo_valid && !slot_ok;
            res_drop_q  <= res_valid && (state_q != ST_IDLE);
        end
    end

    byte_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .n_rst   (n_rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (tx_data),
        .cnt     (fifo_cnt)
    );

    assign tx_valid  = (fifo_cnt != '0);
    assign busy      = (state_q != ST_IDLE);
    assign echo_drop = echo_drop_q;
    assign res_drop  = res_drop_q;

endmodule

// File: tb/tb_uart_resp_fmt.sv
// Directed testbench for uart_resp_fmt: one instance with leading-zero suppression, one without.
// Honours UART_RESP_CRLF_EN when building expected terminators.
module tb_uart_resp_fmt;

    logic        clk = 1'b0;
    logic        nRst;
    logic [7:0]  echoData;
    logic        echoValid;
    logic [31:0] resData;
    logic        resValid;
    logic [7:0]  txData;
    logic        txValid;
    logic        txReady;
    logic [4:0]  fifoCnt;
    logic        busy, echoDrop, resDrop;

    logic [31:0] resData0;
    logic        resValid0;
    logic [7:0]  txData0;
    logic        txValid0;
    logic [4:0]  fifoCnt0;
    logic        busy0, echoDrop0, resDrop0;

    int nCompared   = 0;
    int nMismatched = 0;

    logic [7:0] rxQ[$];
    logic [7:0] rxQ0[$];
    logic [7:0] expQ[$];

    always #5 clk = ~clk;

    uart_resp_fmt #(.RES_W(32), .DEPTH(16), .SUPPRESS_LZ(1)) dut (
        .clk(clk), .n_rst(nRst), .echo_data(echoData), .echo_valid(echoValid),
        .res_data(resData), .res_valid(resValid), .tx_data(txData), .tx_valid(txValid),
        .tx_ready(txReady), .fifo_cnt(fifoCnt), .busy(busy), .echo_drop(echoDrop),
        .res_drop(resDrop)
    );

    uart_resp_fmt #(.RES_W(32), .DEPTH(16), .SUPPRESS_LZ(0)) dut0 (
        .clk(clk), .n_rst(nRst), .echo_data(8'h00), .echo_valid(1'b0),
        .res_data(resData0), .res_valid(resValid0), .tx_data(txData0), .tx_valid(txValid0),
        .tx_ready(1'b1), .fifo_cnt(fifoCnt0), .busy(busy0), .echo_drop(echoDrop0),
        .res_drop(resDrop0)
    );

    // Every byte popped by the transmitter is logged mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (nRst && txValid && txReady) rxQ.push_back(txData);
        if (nRst && txValid0) rxQ0.push_back(txData0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic build_exp(input string s);
        expQ.delete();
        for (int i = 0; i < s.len(); i++) expQ.push_back(s[i]);
`ifdef UART_RESP_CRLF_EN
        expQ.push_back(8'h0D);
`endif
        expQ.push_back(8'h0A);
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (!busy && !txValid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tick();
    endtask

    task automatic wait_done0(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (!busy0 && !txValid0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tick();
    endtask

    task automatic pulse_res(input logic [31:0] value);
        resData  = value;
        resValid = 1'b1;
        tick();
        resValid = 1'b0;
    endtask

    task automatic test_reset();
        nRst = 1'b0;
        #12;
        nCompared++; if (txValid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_tx_valid: got %0b expected 0", txValid); end
        nCompared++; if (fifoCnt !== 5'd0) begin nMismatched++; $display("[TB] FAIL reset_fifo_cnt: got %0d expected 0", fifoCnt); end
        nCompared++; if (txData !== 8'h00) begin nMismatched++; $display("[TB] FAIL reset_tx_data: got %0h expected 0", txData); end
        nCompared++; if ({busy, echoDrop, resDrop} !== 3'b000) begin nMismatched++; $display("[TB] FAIL reset_flags: got %b expected 000", {busy, echoDrop, resDrop}); end
        @(posedge clk);
        #1 nRst = 1'b1;
        tick();
    endtask

    task automatic test_latency_no_lz();
        int  base = rxQ0.size();
        bit  ok;
        resData0  = 32'h0000_00FF;
        resValid0 = 1'b1;
        tick();
        resValid0 = 1'b0;
        nCompared++; if (txValid0 !== 1'b0 || busy0 !== 1'b1) begin nMismatched++; $display("[TB] FAIL lat_edge_k: got valid=%0b busy=%0b expected valid=0 busy=1", txValid0, busy0); end
        tick();
        nCompared++; if (txValid0 !== 1'b1 || txData0 !== 8'h30) begin nMismatched++; $display("[TB] FAIL lat_first_char: got valid=%0b data=%0h expected valid=1 data=30", txValid0, txData0); end
        wait_done0(ok);
        nCompared++; if (!ok) begin nMismatched++; $display("[TB] FAIL nolz_timeout: got busy=%0b expected 0", busy0); end
        build_exp("000000FF");
        nCompared++; if (rxQ0.size() - base !== expQ.size()) begin nMismatched++; $display("[TB] FAIL nolz_len: got %0d expected %0d", rxQ0.size() - base, expQ.size()); end
        for (int i = 0; i < expQ.size(); i++) begin
            logic [7:0] got = (base + i < rxQ0.size()) ? rxQ0[base + i] : 8'hxx;
            nCompared++; if (got !== expQ[i]) begin nMismatched++; $display("[TB] FAIL nolz_byte%0d: got %0h expected %0h", i, got, expQ[i]); end
        end
    endtask

    task automatic test_hex_suppress();
        int base = rxQ.size();
        int term;
        bit ok;
`ifdef UART_RESP_CRLF_EN
        term = 2;
`else
        term = 1;
`endif
        txReady = 1'b1;
        pulse_res(32'h0000_1A2F);
        // Four skipped zeros plus four digits, then the terminator writes.
        for (int i = 0; i < 8 + term - 1; i++) tick();
        nCompared++; if (busy !== 1'b1) begin nMismatched++; $display("[TB] FAIL busy_before_term: got %0b expected 1", busy); end
        tick();
        nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL busy_after_term: got %0b expected 0", busy); end
        wait_done(ok);
        build_exp("1A2F");
        nCompared++; if (rxQ.size() - base !== expQ.size()) begin nMismatched++; $display("[TB] FAIL hex_len: got %0d expected %0d", rxQ.size() - base, expQ.size()); end
        for (int i = 0; i < expQ.size(); i++) begin
            logic [7:0] got = (base + i < rxQ.size()) ? rxQ[base + i] : 8'hxx;
            nCompared++; if (got !== expQ[i]) begin nMismatched++; $display("[TB] FAIL hex_byte%0d: got %0h expected %0h", i, got, expQ[i]); end
        end
    endtask

    task automatic test_zero_and_deadbeef();
        int base = rxQ.size();
        bit ok;
        pulse_res(32'h0000_0000);
        wait_done(ok);
        nCompared++; if (!ok) begin nMismatched++; $display("[TB] FAIL zero_timeout: got busy=%0b expected 0", busy); end
        build_exp("0");
        nCompared++; if (rxQ.size() - base !== expQ.size()) begin nMismatched++; $display("[TB] FAIL zero_len: got %0d expected %0d", rxQ.size() - base, expQ.size()); end
        for (int i = 0; i < expQ.size(); i++) begin
            logic [7:0] got = (base + i < rxQ.size()) ? rxQ[base + i] : 8'hxx;
            nCompared++; if (got !== expQ[i]) begin nMismatched++; $display("[TB] FAIL zero_byte%0d: got %0h expected %0h", i, got, expQ[i]); end
        end
        base = rxQ.size();
        pulse_res(32'hDEAD_BEEF);
        wait_done(ok);
        build_exp("DEADBEEF");
        nCompared++; if (rxQ.size() - base !== expQ.size()) begin nMismatched++; $display("[TB] FAIL dead_len: got %0d expected %0d", rxQ.size() - base, expQ.size()); end
        for (int i = 0; i < expQ.size(); i++) begin
            logic [7:0] got = (base + i < rxQ.size()) ? rxQ[base + i] : 8'hxx;
            nCompared++; if (got !== expQ[i]) begin nMismatched++; $display("[TB] FAIL dead_byte%0d: got %0h expected %0h", i, got, expQ[i]); end
        end
    endtask

    task automatic test_fifo_full();
        int drops = 0;
        int base;
        bit ok;
        txReady = 1'b0;
        for (int i = 0; i < 20; i++) begin
            echoData  = 8'h60 + 8'(i);
            echoValid = 1'b1;
            tick();
            if (echoDrop) drops++;
        end
        echoValid = 1'b0;
        tick();
        nCompared++; if (fifoCnt !== 5'd16) begin nMismatched++; $display("[TB] FAIL full_cnt: got %0d expected 16", fifoCnt); end
        nCompared++; if (drops !== 4) begin nMismatched++; $display("[TB] FAIL full_drops: got %0d expected 4", drops); end
        nCompared++; if (txData !== 8'h60) begin nMismatched++; $display("[TB] FAIL full_head: got %0h expected 60", txData); end
        base = rxQ.size();
        txReady = 1'b1;
        wait_done(ok);
        nCompared++; if (rxQ.size() - base !== 16) begin nMismatched++; $display("[TB] FAIL drain_len: got %0d expected 16", rxQ.size() - base); end
        for (int i = 0; i < 16; i++) begin
            logic [7:0] got = (base + i < rxQ.size()) ? rxQ[base + i] : 8'hxx;
            nCompared++; if (got !== 8'h60 + 8'(i)) begin nMismatched++; $display("[TB] FAIL drain_byte%0d: got %0h expected %0h", i, got, 8'h60 + 8'(i)); end
        end
    endtask

    task automatic test_echo_contention();
        int base = rxQ.size();
        bit ok;
        txReady = 1'b1;
        pulse_res(32'h1234_5678);
        tick();
        echoData  = 8'h55;
        echoValid = 1'b1;
        tick();
        echoValid = 1'b0;
        resData   = 32'h9999_9999;
        resValid  = 1'b1;
        tick();
        resValid = 1'b0;
        nCompared++; if (resDrop !== 1'b1) begin nMismatched++; $display("[TB] FAIL res_drop_pulse: got %0b expected 1", resDrop); end
        tick();
        nCompared++; if (resDrop !== 1'b0) begin nMismatched++; $display("[TB] FAIL res_drop_clear: got %0b expected 0", resDrop); end
        wait_done(ok);
        nCompared++; if (!ok) begin nMismatched++; $display("[TB] FAIL mix_timeout: got busy=%0b expected 0", busy); end
        build_exp("12345678");
        expQ.insert(1, 8'h55);
        nCompared++; if (rxQ.size() - base !== expQ.size()) begin nMismatched++; $display("[TB] FAIL mix_len: got %0d expected %0d", rxQ.size() - base, expQ.size()); end
        for (int i = 0; i < expQ.size(); i++) begin
            logic [7:0] got = (base + i < rxQ.size()) ? rxQ[base + i] : 8'hxx;
            nCompared++; if (got !== expQ[i]) begin nMismatched++; $display("[TB] FAIL mix_byte%0d: got %0h expected %0h", i, got, expQ[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int base;
        bit ok;
        txReady = 1'b0;
        pulse_res(32'hCAFE_BABE);
        tick();
        tick();
        tick();
        nCompared++; if (fifoCnt !== 5'd3) begin nMismatched++; $display("[TB] FAIL mid_cnt_before: got %0d expected 3", fifoCnt); end
        #1 nRst = 1'b0;
        #1;
        nCompared++; if (txValid !== 1'b0 || fifoCnt !== 5'd0) begin nMismatched++; $display("[TB] FAIL mid_reset: got valid=%0b cnt=%0d expected valid=0 cnt=0", txValid, fifoCnt); end
        nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL mid_reset_busy: got %0b expected 0", busy); end
        @(posedge clk);
        #1 nRst = 1'b1;
        txReady = 1'b1;
        tick();
        base = rxQ.size();
        pulse_res(32'h0000_00AB);
        wait_done(ok);
        build_exp("AB");
        nCompared++; if (rxQ.size() - base !== expQ.size()) begin nMismatched++; $display("[TB] FAIL post_len: got %0d expected %0d", rxQ.size() - base, expQ.size()); end
        for (int i = 0; i < expQ.size(); i++) begin
            logic [7:0] got = (base + i < rxQ.size()) ? rxQ[base + i] : 8'hxx;
            nCompared++; if (got !== expQ[i]) begin nMismatched++; $display("[TB] FAIL post_byte%0d: got %0h expected %0h", i, got, expQ[i]); end
        end
    endtask

    initial begin
        echoData  = 8'h00;
        echoValid = 1'b0;
        resData   = '0;
        resValid  = 1'b0;
        txReady   = 1'b1;
        resData0  = '0;
        resValid0 = 1'b0;
        test_reset();
        test_latency_no_lz();
        test_hex_suppress();
        test_zero_and_deadbeef();
        test_fifo_full();
        test_echo_contention();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
